// File: rtl/fme.sv
// Quarter-pel interpolator: 6-tap half-pel filter on a constant reference row,
// averaged with the integer sample. Three register stages, one result per clock.
module fme #(
  parameter int PIX_W    = 8,
  parameter int EDGE_POS = 192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_pos,
  output logic [PIX_W-1:0] quat_val
);

  // Reference row lookup with edge replication: out-of-range indices clamp to 0..255.
  function automatic logic [7:0] ref_row(input logic signed [9:0] idx);
    logic [7:0] addr;
    if (idx < 10'sd0)
      addr = 8'd0;
    else if (idx > 10'sd255)
      addr = 8'd255;
    else
      addr = idx[7:0];
    if (int'(addr) < EDGE_POS)
      return addr;
    else
      return 8'd0;
  endfunction

  logic signed [9:0] tap_idx  [6];
  logic [7:0]        tap_val  [6];
  logic [7:0]        tap_reg  [6];
  logic [7:0]        c1_reg;

  logic signed [15:0] tap_ext [6];
  logic signed [15:0] sum;
  logic signed [15:0] half_raw;
  logic [7:0]         half_clip;
  logic [7:0]         h2_reg;
  logic [7:0]         c2_reg;

  logic [8:0]         avg;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_tap
      assign tap_idx[gi] = signed'({2'b00, pix_pos}) + 10'(gi - 2);
      assign tap_val[gi] = ref_row(tap_idx[gi]);
      assign tap_ext[gi] = signed'({8'b0, tap_reg[gi]});
    end
  endgenerate

  // Stage 1: fetch taps and centre sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) tap_reg[i] <= 8'd0;
      c1_reg <= 8'd0;
    end else begin
      for (int i = 0; i < 6; i++) tap_reg[i] <= tap_val[i];
      c1_reg <= tap_val[2];
    end
  end

  // Half-pel filter; sum spans -2550..10710 so 16 signed bits are ample.
  always_comb begin
    sum = tap_ext[0] - 16'sd5 * tap_ext[1] + 16'sd20 * tap_ext[2]
        + 16'sd20 * tap_ext[3] - 16'sd5 * tap_ext[4] + tap_ext[5];
    half_raw = (sum + 16'sd16) >>> 5;
    half_clip = 8'd0;
    if (half_raw < 16'sd0)
      half_clip = 8'd0;
    else if (half_raw > 16'sd255)
      half_clip = 8'd255;
    else
      half_clip = half_raw[7:0];
  end

  // Stage 2: clipped half-pel sample and delayed centre sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      h2_reg <= 8'd0;
      c2_reg <= 8'd0;
    end else begin
      h2_reg <= half_clip;
      c2_reg <= c1_reg;
    end
  end

  assign avg = {1'b0, c2_reg} + {1'b0, h2_reg} + 9'd1;

  // Stage 3: rounded average.
  always_ff @(posedge clk) begin
    if (rst)
      quat_val <= '0;
    else
      quat_val <= PIX_W'(avg[8:1]);
  end

endmodule

// File: tb/tb_fme.sv
// Bench for fme: table vectors plus random stream, checked through an
// expected-output queue that mirrors the 3-edge pipeline delay.
module tb_fme;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_pos = 8'd0;
  logic [7:0] quat_val;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  fme #(.PIX_W(8), .EDGE_POS(192)) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_pos  (pix_pos),
    .quat_val (quat_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pos;
    int         expv;
  } vec_t;

  // Reference model straight from the arithmetic definition.
  function automatic int row_val(input int i);
    int k;
    k = (i < 0) ? 0 : ((i > 255) ? 255 : i);
    return (k < 192) ? k : 0;
  endfunction

  function automatic int model(input int pos);
    int s, h, c;
    s = row_val(pos - 2) - 5 * row_val(pos - 1) + 20 * row_val(pos)
      + 20 * row_val(pos + 1) - 5 * row_val(pos + 2) + row_val(pos + 3);
    h = (s + 16) >>> 5;
    if (h < 0) h = 0;
    if (h > 255) h = 255;
    c = row_val(pos);
    return (c + h + 1) / 2;
  endfunction

  task automatic compare(input string name, input int expv);
    checks++;
    if (int'(quat_val) != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, quat_val, expv);
    end
  endtask

  // One clock with rst=0: queue the expected output for pos, compare the oldest.
  task automatic step(input logic [7:0] pos, input int expv, input string name);
    int e;
    rst = 1'b0;
    pix_pos = pos;
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    e = exp_q.pop_front();
    compare(name, e);
    $display("step %-8s pos=%0d quat_val=%0d exp=%0d", name, pos, quat_val, e);
  endtask

  // One clock with rst=1: output must read 0 and the next two outputs too.
  task automatic reset_edge(input string name);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(0);
    compare(name, 0);
    $display("reset %-8s quat_val=%0d exp=0", name, quat_val);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'd0,   0};
    vecs[1]  = '{8'd255, 0};
    vecs[2]  = '{8'd190, 202};
    vecs[3]  = '{8'd192, 0};
    vecs[4]  = '{8'd191, 144};
    vecs[5]  = '{8'd100, 101};
    vecs[6]  = '{8'd190, 202};
    vecs[7]  = '{8'd191, 144};
    vecs[8]  = '{8'd193, 3};
    vecs[9]  = '{8'd1,   model(1)};
    vecs[10] = '{8'd50,  51};
    vecs[11] = '{8'd200, 0};

    reset_edge("rst0");
    reset_edge("rst1");

    // Hold 100 after release: 0, 0, then 101.
    for (int i = 0; i < 5; i++) step(8'd100, 101, "hold100");

    for (int i = 0; i < 12; i++) step(vecs[i].pos, vecs[i].expv, "table");

    for (int i = 0; i < 30; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      step(r, model(int'(r)), "random");
    end

    // Mid-stream reset: in-flight values are dropped, output 0 for 3 edges.
    step(8'd100, 101, "pre_rst");
    step(8'd190, 202, "pre_rst");
    reset_edge("mid_rst");
    step(8'd191, 144, "refill");
    step(8'd193, 3,   "refill");
    step(8'd100, 101, "refill");
    step(8'd190, 202, "refill");
    step(8'd0,   0,   "drain");
    step(8'd0,   0,   "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fme.md
Name: fme

Overview:
- Fractional-pel interpolation stage of the motion-estimation datapath.
- For integer position pix_pos on an internal 256-sample reference row, it produces the quarter-pel sample at pix_pos+1/4.
- The half-pel sample uses the 6-tap filter (1,-5,20,20,-5,1)/32. The quarter-pel sample is the rounded average of the integer sample and that half-pel sample.
- Fully pipelined: one result per clock, fixed 3-cycle latency.

Parameters:
- PIX_W, 8, pixel and position width (fixed at 8 for this revision).
- EDGE_POS, 192, first index of the zero region of the internal reference row.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pix_pos  in  8  integer sample index 0..255; sampled every cycle.
- quat_val  out  8  registered quarter-pel sample for the pix_pos presented 3 cycles earlier.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-high. While rst=1 at a rising edge, every pipeline register and quat_val clear to 0.
- Reference row: internal constant ROM p(i), i=0..255.
  - p(i)=i for i<EDGE_POS.
  - p(i)=0 for i>=EDGE_POS.
  - Implement as combinational function or case table; no write port.
- Tap addressing: taps at indices pix_pos-2, -1, 0, +1, +2, +3. Each index is clamped to 0..255 (edge replication); no wrap-around.
- Stage 1 (edge N, pix_pos valid before edge N): register the six tap values and the centre value c=p(pix_pos).
- Stage 2 (edge N+1):
  - s = t0 - 5*t1 + 20*t2 + 20*t3 - 5*t4 + t5, signed, at least 15 bits.
  - h = (s+16)>>>5, arithmetic shift.
  - Clip h to 0..255; register h and c.
- Stage 3 (edge N+2): quat_val <= (c + h + 1)>>1, 9-bit intermediate, so the result never exceeds 255.
- Latency: a pix_pos set up before edge N appears on quat_val after edge N+2, i.e. 3 rising edges inclusive of the sampling edge.
- Throughput: a new pix_pos every cycle; no stalls and no handshake.
- After reset deasserts, the first 2 outputs come from the zeroed pipeline and read 0. Valid data appears from the 3rd edge after release.
- Reset mid-stream: all in-flight results are discarded. Output stays 0 until the pipeline refills.
- pix_pos changing every cycle is legal; each value propagates independently.

Test Plan:
- Reset, then hold pix_pos=100 with rst=0 -> quat_val=0 for the first 2 edges, then 101 from the 3rd edge on (h=101, c=100).
- pix_pos=0 (low clamp) -> s=13, h=0, quat_val=0.
- pix_pos=255 (high clamp, p(255)=0) -> quat_val=0. Also pix_pos=190 -> s=6863, h=214, quat_val=202.
- Negative clip: pix_pos=192 -> s=-765, h clipped to 0, quat_val=0. Also pix_pos=191 -> h=96, quat_val=144.
- Back-to-back stream 100,190,191,193 on consecutive cycles -> quat_val 101,202,144,3 on consecutive cycles starting 3 edges after the first input.
- Assert rst for one edge mid-stream -> quat_val=0 at that edge and the following 2 edges, then normal results resume.
